// File: rtl/tug_of_war_match.sv
// Tug-of-war match: N-light playfield with edge-detected key presses,
// per-player scoring, a timed post-point pause and a match-over latch.
module tug_of_war_match #(
  parameter int N            = 9,
  parameter int WIN_ROUNDS   = 3,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         L_in,
  input  logic         R_in,
  output logic [N-1:0] lights,
  output logic [2:0]   left_score,
  output logic [2:0]   right_score,
  output logic [6:0]   HEX_L,
  output logic [6:0]   HEX_R,
  output logic         match_over,
  output logic         winner_left
);

  localparam int PW = $clog2(N);
  localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [PW-1:0] CENTRE     = PW'((N - 1) / 2);
  localparam logic [PW-1:0] LEFT_END   = PW'(N - 1);
  localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);
  localparam logic [2:0]    WIN        = 3'(WIN_ROUNDS);

  typedef enum logic [1:0] {PLAY, POINT, OVER} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pos, pos_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    left_n, right_n;
  logic          over_n, winl_n;
  logic          l_d, r_d;
  logic          lp, rp;

  assign lp = L_in & ~l_d;
  assign rp = R_in & ~r_d;

  // Key history loads the live level during reset so a held key is not a press.
  always_ff @(posedge Clock) begin
    l_d <= L_in;
    r_d <= R_in;
    if (Reset) begin
      state       <= PLAY;
      pos         <= CENTRE;
      cnt         <= '0;
      left_score  <= '0;
      right_score <= '0;
      match_over  <= 1'b0;
      winner_left <= 1'b0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      cnt         <= cnt_n;
      left_score  <= left_n;
      right_score <= right_n;
      match_over  <= over_n;
      winner_left <= winl_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    cnt_n   = cnt;
    left_n  = left_score;
    right_n = right_score;
    over_n  = match_over;
    winl_n  = winner_left;
    case (state)
      PLAY: begin
        if (lp && !rp) begin
          if (pos == LEFT_END) begin
            left_n = left_score + 3'd1;
            if (left_n == WIN) begin
              state_n = OVER;
              over_n  = 1'b1;
              winl_n  = 1'b1;
            end else begin
              state_n = POINT;
              cnt_n   = PAUSE_LOAD;
            end
          end else begin
            pos_n = pos + PW'(1);
          end
        end else if (rp && !lp) begin
          if (pos == '0) begin
            right_n = right_score + 3'd1;
            if (right_n == WIN) begin
              state_n = OVER;
              over_n  = 1'b1;
              winl_n  = 1'b0;
            end else begin
              state_n = POINT;
              cnt_n   = PAUSE_LOAD;
            end
          end else begin
            pos_n = pos - PW'(1);
          end
        end
      end
      POINT: begin
        if (cnt == '0) begin
          pos_n   = CENTRE;
          state_n = PLAY;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      OVER:    state_n = OVER;
      default: state_n = PLAY;
    endcase
  end

  always_comb lights = N'(1) << pos;

  function automatic logic [6:0] seg7(input logic [2:0] d);
    case (d)
      3'd0:    seg7 = 7'b1000000;
      3'd1:    seg7 = 7'b1111001;
      3'd2:    seg7 = 7'b0100100;
      3'd3:    seg7 = 7'b0110000;
      3'd4:    seg7 = 7'b0011001;
      3'd5:    seg7 = 7'b0010010;
      3'd6:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111000;
    endcase
  endfunction

  assign HEX_L = seg7(left_score);
  assign HEX_R = seg7(right_score);

endmodule

// File: tb/tb_tug_of_war_match.sv
// Bench for tug_of_war_match: a cycle-level game model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tug_of_war_match;

  localparam int N = 9;
  localparam int WR = 3;
  localparam int PC = 4;
  localparam int C = (N - 1) / 2;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         L_in = 1'b0;
  logic         R_in = 1'b0;
  logic [N-1:0] lights;
  logic [2:0]   left_score, right_score;
  logic [6:0]   HEX_L, HEX_R;
  logic         match_over, winner_left;

  int tests = 0;
  int fails = 0;
  bit run_cmp = 1'b0;

  tug_of_war_match #(.N(N), .WIN_ROUNDS(WR), .PAUSE_CYCLES(PC)) dut (
    .Clock(Clock), .Reset(Reset), .L_in(L_in), .R_in(R_in),
    .lights(lights), .left_score(left_score), .right_score(right_score),
    .HEX_L(HEX_L), .HEX_R(HEX_R), .match_over(match_over),
    .winner_left(winner_left)
  );

  always #5 Clock = ~Clock;

  logic [6:0] seg [0:7] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: pause counts remaining lit cycles after a point.
  int m_pos = C, m_ls = 0, m_rs = 0, m_pause = 0;
  bit m_over = 0, m_win = 0, m_pl = 0, m_pr = 0;

  always @(posedge Clock) begin
    bit lp, rp;
    lp = L_in && !m_pl;
    rp = R_in && !m_pr;
    m_pl = L_in;
    m_pr = R_in;
    if (Reset) begin
      m_pos = C; m_ls = 0; m_rs = 0; m_pause = 0; m_over = 0; m_win = 0;
    end else if (m_over) begin
      // frozen
    end else if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) m_pos = C;
    end else if (lp && !rp) begin
      if (m_pos == N - 1) begin
        m_ls++;
        if (m_ls == WR) begin m_over = 1; m_win = 1; end
        else m_pause = PC;
      end else m_pos++;
    end else if (rp && !lp) begin
      if (m_pos == 0) begin
        m_rs++;
        if (m_rs == WR) begin m_over = 1; m_win = 0; end
        else m_pause = PC;
      end else m_pos--;
    end
  end

  always @(negedge Clock) begin
    if (run_cmp) begin
      logic [N-1:0] exp_l;
      exp_l = '0;
      exp_l[m_pos] = 1'b1;
      check("cyc_lights", 32'(lights), 32'(exp_l));
      check("cyc_left_score", 32'(left_score), 32'(m_ls));
      check("cyc_right_score", 32'(right_score), 32'(m_rs));
      check("cyc_hex_l", 32'(HEX_L), 32'(seg[m_ls]));
      check("cyc_hex_r", 32'(HEX_R), 32'(seg[m_rs]));
      check("cyc_match_over", 32'(match_over), 32'(m_over));
      if (m_over) check("cyc_winner_left", 32'(winner_left), 32'(m_win));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_l();
    L_in = 1'b1; tick(); L_in = 1'b0; tick();
  endtask

  task automatic pulse_r();
    R_in = 1'b1; tick(); R_in = 1'b0; tick();
  endtask

  initial begin
    // 1: reset
    tick(); tick();
    Reset = 1'b0;
    run_cmp = 1'b1;
    check("rst_lights", 32'(lights), 32'(9'b000010000));
    check("rst_scores", 32'({left_score, right_score}), 32'(0));
    check("rst_hex_l", 32'(HEX_L), 32'(7'b1000000));
    check("rst_hex_r", 32'(HEX_R), 32'(7'b1000000));
    check("rst_over", 32'(match_over), 32'(0));

    // 2: walk right and score
    repeat (4) pulse_r();
    check("right_end", 32'(lights), 32'(9'b000000001));
    R_in = 1'b1; tick();
    check("r_point_score", 32'(right_score), 32'(1));
    check("r_point_hex", 32'(HEX_R), 32'(7'b1111001));
    check("r_point_light", 32'(lights), 32'(9'b000000001));
    R_in = 1'b0;
    for (int i = 0; i < PC - 1; i++) begin
      tick();
      check("pause_hold", 32'(lights), 32'(9'b000000001));
    end
    tick();
    check("pause_recentre", 32'(lights), 32'(9'b000010000));

    // 3: simultaneous press, then a long hold
    L_in = 1'b1; R_in = 1'b1; tick();
    check("both_press", 32'(lights), 32'(9'b000010000));
    L_in = 1'b0; R_in = 1'b0; tick();
    L_in = 1'b1;
    repeat (10) tick();
    check("held_one_move", 32'(lights), 32'(9'b000100000));
    L_in = 1'b0; tick();

    // 4: presses during the pause are ignored
    repeat (3) pulse_l();
    L_in = 1'b1; tick();
    check("l_point_score", 32'(left_score), 32'(1));
    L_in = 1'b0; tick();
    R_in = 1'b1; tick();
    R_in = 1'b0; L_in = 1'b1; tick();
    repeat (3) tick();
    check("pause_ignore_lights", 32'(lights), 32'(9'b000010000));
    check("pause_ignore_scores", 32'({left_score, right_score}), 32'({3'd1, 3'd1}));
    L_in = 1'b0; tick();

    // 5: left wins the match
    repeat (4) pulse_l();
    L_in = 1'b1; tick(); L_in = 1'b0;
    repeat (PC) tick();
    repeat (4) pulse_l();
    L_in = 1'b1; tick();
    check("win_over", 32'(match_over), 32'(1));
    check("win_left", 32'(winner_left), 32'(1));
    check("win_score", 32'(left_score), 32'(3));
    check("win_hex", 32'(HEX_L), 32'(7'b0110000));
    check("win_lights", 32'(lights), 32'(9'b100000000));
    L_in = 1'b0; tick();
    pulse_r(); pulse_r(); pulse_l();
    check("over_frozen_lights", 32'(lights), 32'(9'b100000000));
    check("over_frozen_scores", 32'({left_score, right_score}), 32'({3'd3, 3'd1}));
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("over_rst_lights", 32'(lights), 32'(9'b000010000));
    check("over_rst_scores", 32'({left_score, right_score}), 32'(0));
    check("over_rst_flag", 32'(match_over), 32'(0));

    // 6: reset mid-pause with a key held through it
    repeat (4) pulse_r();
    R_in = 1'b1; tick(); R_in = 1'b0;
    check("mid_point_score", 32'(right_score), 32'(1));
    tick();
    Reset = 1'b1; L_in = 1'b1; tick();
    check("mid_rst_lights", 32'(lights), 32'(9'b000010000));
    check("mid_rst_score", 32'(right_score), 32'(0));
    Reset = 1'b0;
    repeat (3) tick();
    check("held_thru_rst", 32'(lights), 32'(9'b000010000));
    L_in = 1'b0; tick();

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
